airi5c_fpu_issue_ctrl: RTL and testbench

- Initiator side of the FPU unit load/kill/ready handshake.
- Accepts one FPU operation request from the core pipeline and issues a one-cycle load to the selected execution unit (sign modifier, adder, multiplier, ...).
- Waits for that unit's ready pulse, captures the unit's 32-bit result, and returns it to the core with a one-cycle result_valid.
- Propagates pipeline flushes to all units as a broadcast kill.

---
 rtl/airi5c_fpu_pkg.sv | 21 ++
 rtl/airi5c_fpu_watchdog.sv | 29 ++
 rtl/airi5c_fpu_issue_ctrl.sv | 112 +++++++++++
 tb/tb_airi5c_fpu_issue_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/airi5c_fpu_pkg.sv
// Shared state encoding, unit indices and operand width for the AIRI5C FPU issue logic.
package airi5c_fpu_pkg;

  localparam int FLEN = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2
  } fpu_issue_state_e;

  typedef enum logic [2:0] {
    UNIT_SGN  = 3'd0,
    UNIT_ADD  = 3'd1,
    UNIT_MUL  = 3'd2,
    UNIT_DIV  = 3'd3,
    UNIT_SQRT = 3'd4,
    UNIT_CVT  = 3'd5
  } fpu_unit_e;

endpackage

// File: rtl/airi5c_fpu_watchdog.sv
// WAIT-state watchdog for the FPU issue controller; only built when AIRI5C_FPU_TIMEOUT_EN is defined.
`ifdef AIRI5C_FPU_TIMEOUT_EN
module airi5c_fpu_watchdog #(
  parameter int LIMIT = 64
) (
  input  logic clk,
  input  logic n_reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [15:0] count;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 16'd1;
    end
  end

  // Fires during the last permitted WAIT cycle so the abort lands exactly LIMIT cycles in.
  assign expired = enable && (count == 16'(LIMIT - 1));

endmodule
`endif

// File: rtl/airi5c_fpu_issue_ctrl.sv
// Issues one FPU operation to a selected unit, waits for its ready pulse and returns the result.
// Optional WAIT-state watchdog enabled with `define AIRI5C_FPU_TIMEOUT_EN.
module airi5c_fpu_issue_ctrl
  import airi5c_fpu_pkg::*;
#(
  parameter int NUM_UNITS      = 6,
  parameter int SEL_W          = 3,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                      clk,
  input  logic                      n_reset,
  input  logic                      req,
  input  logic                      kill,
  input  logic [SEL_W-1:0]          unit_sel,
  output logic                      busy,
  output logic [NUM_UNITS-1:0]      unit_load,
  output logic                      unit_kill,
  input  logic [NUM_UNITS-1:0]      unit_ready,
  input  logic [FLEN*NUM_UNITS-1:0] unit_result,
  output logic [FLEN-1:0]           result,
  output logic                      result_valid,
  output logic                      err
);

  localparam logic [SEL_W:0]       UNITS_LIM = (SEL_W + 1)'(NUM_UNITS);
  localparam logic [NUM_UNITS-1:0] ONE_HOT0  = NUM_UNITS'(1);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535 || (1 << SEL_W) < NUM_UNITS) begin : g_bad_params
    $error("airi5c_fpu_issue_ctrl: illegal parameter combination");
  end

  fpu_issue_state_e state;
  logic [SEL_W-1:0] sel_q;
  logic [31:0]      sel_base;
  logic             sel_ready;
  logic [FLEN-1:0]  sel_result;
  logic             wd_expired;

  assign busy       = (state != IDLE);
  assign sel_base   = 32'(sel_q) * FLEN;
  assign sel_ready  = unit_ready[sel_q];
  assign sel_result = unit_result[sel_base +: FLEN];

`ifdef AIRI5C_FPU_TIMEOUT_EN
  airi5c_fpu_watchdog #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .n_reset(n_reset),
    .clear  (state != WAIT),
    .enable (state == WAIT),
    .expired(wd_expired)
  );
`else
  assign wd_expired = 1'b0;
`endif

  // Strobes default low each cycle; kill overrides every state, and the selected ready beats a timeout.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state        <= IDLE;
      sel_q        <= '0;
      unit_load    <= '0;
      unit_kill    <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      err          <= 1'b0;
    end else begin
      unit_load    <= '0;
      unit_kill    <= 1'b0;
      result_valid <= 1'b0;
      err          <= 1'b0;
      if (kill) begin
        state     <= IDLE;
        unit_kill <= 1'b1;
      end else begin
        unique case (state)
          IDLE: begin
            if (req) begin
              if ({1'b0, unit_sel} < UNITS_LIM) begin
                sel_q     <= unit_sel;
                unit_load <= ONE_HOT0 << unit_sel;
                state     <= LOAD;
              end else begin
                result       <= '0;
                result_valid <= 1'b1;
                err          <= 1'b1;
              end
            end
          end
          LOAD, WAIT: begin
            if (sel_ready) begin
              result       <= sel_result;
              result_valid <= 1'b1;
              state        <= IDLE;
            end else if (state == WAIT && wd_expired) begin
              unit_kill    <= 1'b1;
              result       <= '0;
              result_valid <= 1'b1;
              err          <= 1'b1;
              state        <= IDLE;
            end else begin
              state <= WAIT;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_airi5c_fpu_issue_ctrl.sv
// Self-checking bench for airi5c_fpu_issue_ctrl: directed + random operations against a transaction-level model.
module tb_airi5c_fpu_issue_ctrl;
  import airi5c_fpu_pkg::*;

  localparam int NU = 6;
  localparam int SW = 3;
`ifdef AIRI5C_FPU_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 64;
`endif
  localparam int MAXC = 4000;

  logic              clk = 1'b0;
  logic              n_reset = 1'b0;
  logic              req = 1'b0;
  logic              kill = 1'b0;
  logic [SW-1:0]     unit_sel = '0;
  logic              busy;
  logic [NU-1:0]     unit_load;
  logic              unit_kill;
  logic [NU-1:0]     unit_ready = '0;
  logic [32*NU-1:0]  unit_result = '0;
  logic [31:0]       result;
  logic              result_valid;
  logic              err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  airi5c_fpu_issue_ctrl #(
    .NUM_UNITS     (NU),
    .SEL_W         (SW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk         (clk),
    .n_reset     (n_reset),
    .req         (req),
    .kill        (kill),
    .unit_sel    (unit_sel),
    .busy        (busy),
    .unit_load   (unit_load),
    .unit_kill   (unit_kill),
    .unit_ready  (unit_ready),
    .unit_result (unit_result),
    .result      (result),
    .result_valid(result_valid),
    .err         (err)
  );

  // kind 0 = operation request, kind 1 = flush with no request.
  // d = cycles from load to the unit's ready; kill_at = cycle of kill relative to req (-1 none).
  typedef struct {
    int          kind;
    int          sel;
    int          d;
    logic [31:0] data;
    int          kill_at;
    int          gap;
  } op_t;

  bit               s_req   [MAXC];
  logic [SW-1:0]    s_sel   [MAXC];
  bit               s_kill  [MAXC];
  logic [NU-1:0]    s_ready [MAXC];
  logic [32*NU-1:0] s_res   [MAXC];
  bit               e_busy  [MAXC];
  logic [NU-1:0]    e_load  [MAXC];
  bit               e_kill  [MAXC];
  bit               e_valid [MAXC];
  bit               e_err   [MAXC];
  bit               e_upd   [MAXC];
  logic [31:0]      e_res   [MAXC];

  task automatic checkOutput(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s cycle %0d: got %h expected %h", name, c, act, exp);
    end
  endtask

  task automatic applyStimulus(input int c);
    req         = s_req[c];
    unit_sel    = s_sel[c];
    kill        = s_kill[c];
    unit_ready  = s_ready[c];
    unit_result = s_res[c];
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quickOp(input int sel, input logic [31:0] data);
    req = 1'b1;
    unit_sel = SW'(sel);
    step();
    req = 1'b0;
    unit_ready = NU'(1) << sel;
    unit_result[32*sel +: 32] = data;
    step();
    unit_ready = '0;
    checkOutput("quick_valid", -1, 32'(result_valid), 32'd1);
    checkOutput("quick_result", -1, result, data);
    step();
  endtask

  // Expected outputs are laid out per absolute cycle from the transaction's timing rules.
  function automatic int scheduleOp(input op_t op, input int c0);
    int rdy, nxt;
    logic [NU-1:0] mask;
    if (op.kind == 1) begin
      s_kill[c0] = 1'b1;
      e_kill[c0+1] = 1'b1;
      return c0 + 1 + op.gap;
    end
    s_req[c0] = 1'b1;
    s_sel[c0] = SW'(op.sel);
    if (op.kill_at == 0) begin
      s_kill[c0] = 1'b1;
      e_kill[c0+1] = 1'b1;
      return c0 + 1 + op.gap;
    end
    if (op.sel >= NU) begin
      e_valid[c0+1] = 1'b1;
      e_err[c0+1]   = 1'b1;
      e_upd[c0+1]   = 1'b1;
      e_res[c0+1]   = 32'h0;
      return c0 + 1 + op.gap;
    end
    mask = NU'(1) << op.sel;
    e_load[c0+1] = mask;
    rdy = c0 + 1 + op.d;
    for (int c = c0 + 1; c <= rdy; c++) s_ready[c] |= NU'($urandom) & ~mask;
    s_ready[rdy] |= mask;
    s_res[rdy][32*op.sel +: 32] = op.data;
    if (op.kill_at > 0) begin
      for (int c = c0 + 1; c <= c0 + op.kill_at; c++) e_busy[c] = 1'b1;
      s_kill[c0+op.kill_at]   = 1'b1;
      e_kill[c0+op.kill_at+1] = 1'b1;
      nxt = (rdy + 1 > c0 + op.kill_at + 1) ? rdy + 1 : c0 + op.kill_at + 1;
    end else begin
      for (int c = c0 + 1; c <= rdy; c++) e_busy[c] = 1'b1;
      e_valid[rdy+1] = 1'b1;
      e_upd[rdy+1]   = 1'b1;
      e_res[rdy+1]   = op.data;
      nxt = rdy + 1;
    end
    return nxt + op.gap;
  endfunction

  initial begin
    op_t         tbl[$];
    op_t         op;
    int          c, ncyc;
    logic [31:0] cur_res;

    for (int i = 0; i < MAXC; i++) begin
      s_sel[i]   = SW'($urandom);
      s_ready[i] = '0;
      e_load[i]  = '0;
      e_res[i]   = '0;
      for (int k = 0; k < NU; k++) s_res[i][32*k +: 32] = $urandom;
    end

    tbl.push_back('{0, int'(UNIT_SGN),  1, 32'hBF800000, -1, 0});
    tbl.push_back('{0, 7,               0, 32'h0,        -1, 0});
    tbl.push_back('{0, int'(UNIT_MUL),  3, 32'h40490FDB, -1, 1});
    tbl.push_back('{0, int'(UNIT_DIV),  2, 32'h12345678,  2, 0});
    tbl.push_back('{0, int'(UNIT_SGN),  1, 32'hCAFEF00D, -1, 0});
    tbl.push_back('{0, int'(UNIT_ADD),  1, 32'h3F800000,  0, 0});
    tbl.push_back('{1, 0,               0, 32'h0,        -1, 1});
    tbl.push_back('{0, int'(UNIT_CVT),  0, 32'h7F7FFFFF, -1, 0});
    tbl.push_back('{0, int'(UNIT_SQRT), 2, 32'h40000000, -1, 0});
    tbl.push_back('{0, 6,               0, 32'h0,        -1, 0});
    tbl.push_back('{0, int'(UNIT_ADD),  2, 32'hDEADBEEF,  3, 0});
    tbl.push_back('{0, int'(UNIT_CVT),  0, 32'h00000001,  1, 2});
    for (int i = 0; i < 180; i++) begin
      op.kind    = ($urandom_range(0, 9) == 0) ? 1 : 0;
      op.sel     = $urandom_range(0, 7);
      op.d       = $urandom_range(0, 3);
      op.data    = $urandom;
      op.kill_at = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 1 + op.d) : -1;
      op.gap     = $urandom_range(0, 2);
      tbl.push_back(op);
    end

    c = 0;
    for (int i = 0; i < tbl.size(); i++) begin
      if (c > MAXC - 20) break;
      c = scheduleOp(tbl[i], c);
    end
    ncyc = c + 3;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_busy",  -1, 32'(busy), 32'd0);
    checkOutput("reset_load",  -1, 32'(unit_load), 32'd0);
    checkOutput("reset_kill",  -1, 32'(unit_kill), 32'd0);
    checkOutput("reset_valid", -1, 32'(result_valid), 32'd0);
    checkOutput("reset_err",   -1, 32'(err), 32'd0);
    checkOutput("reset_result", -1, result, 32'h0);
    n_reset = 1'b1;

    cur_res = 32'h0;
    for (int i = 0; i < ncyc; i++) begin
      applyStimulus(i);
      if (e_upd[i]) cur_res = e_res[i];
      checkOutput("busy",      i, 32'(busy), 32'(e_busy[i]));
      checkOutput("unit_load", i, 32'(unit_load), 32'(e_load[i]));
      checkOutput("unit_kill", i, 32'(unit_kill), 32'(e_kill[i]));
      checkOutput("valid",     i, 32'(result_valid), 32'(e_valid[i]));
      checkOutput("err",       i, 32'(err), 32'(e_err[i]));
      checkOutput("result",    i, result, cur_res);
      step();
    end
    req = 1'b0;
    kill = 1'b0;
    unit_ready = '0;

    quickOp(int'(UNIT_CVT), 32'h3F800000);
    req = 1'b1;
    unit_sel = SW'(UNIT_SQRT);
    step();
    req = 1'b0;
`ifdef AIRI5C_FPU_TIMEOUT_EN
    for (int t = 1; t <= 5; t++) begin
      checkOutput("to_busy",  t, 32'(busy), 32'd1);
      checkOutput("to_early", t, 32'(result_valid), 32'd0);
      step();
    end
    checkOutput("to_valid",  6, 32'(result_valid), 32'd1);
    checkOutput("to_err",    6, 32'(err), 32'd1);
    checkOutput("to_kill",   6, 32'(unit_kill), 32'd1);
    checkOutput("to_result", 6, result, 32'h0);
    checkOutput("to_idle",   6, 32'(busy), 32'd0);
`else
    for (int t = 1; t <= 100; t++) begin
      checkOutput("hold_busy",  t, 32'(busy), 32'd1);
      checkOutput("hold_valid", t, 32'(result_valid), 32'd0);
      step();
    end
    kill = 1'b1;
    step();
    kill = 1'b0;
    checkOutput("hold_kill", -1, 32'(unit_kill), 32'd1);
    checkOutput("hold_idle", -1, 32'(busy), 32'd0);
    checkOutput("hold_novalid", -1, 32'(result_valid), 32'd0);
`endif
    step();

    quickOp(int'(UNIT_ADD), 32'h40A00000);
    req = 1'b1;
    unit_sel = SW'(UNIT_MUL);
    step();
    req = 1'b0;
    checkOutput("rst_mid_load", -1, 32'(unit_load), 32'b000100);
    step();
    checkOutput("rst_mid_busy", -1, 32'(busy), 32'd1);
    n_reset = 1'b0;
    #1;
    checkOutput("rst_mid_idle",   -1, 32'(busy), 32'd0);
    checkOutput("rst_mid_nokill", -1, 32'(unit_kill), 32'd0);
    checkOutput("rst_mid_result", -1, result, 32'h0);
    step();
    n_reset = 1'b1;
    step();
    checkOutput("rst_after_kill", -1, 32'(unit_kill), 32'd0);
    checkOutput("rst_after_busy", -1, 32'(busy), 32'd0);
    quickOp(int'(UNIT_SGN), 32'h80000000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
